dmem_ctrl: RTL
==============

Name: dmem_ctrl

Overview:
Data-memory access controller between the execute stage and a single-port, word-wide synchronous data RAM with no byte enables.
- Loads: issues the word read, then presents the raw word to the load-extension stage with its address mode and byte select.
- Byte/half stores: performed as read-modify-write.
- Word stores: single write.
- Single outstanding request; ready/valid handshake upstream.

Parameters:
A_WIDTH, 32, byte address width
D_WIDTH, 32, data/RAM word width (fixed 32 for lane logic)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept (IDLE only)
req_we  input  1  1=store, 0=load
req_addrmode  input  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  input  A_WIDTH  byte address
req_wdata  input  D_WIDTH  store data, right-aligned
resp_valid  output  1  one-cycle completion pulse (loads and stores)
resp_err  output  1  misaligned access, qualified by resp_valid
resp_ramout  output  D_WIDTH  raw RAM word for loads, 0 otherwise
resp_addrmode  output  3  latched addrmode, to load-extension stage
resp_selectbytes  output  2  latched addr[1:0], to load-extension stage
ram_addr  output  A_WIDTH-2  word address = latched addr[A_WIDTH-1:2]
ram_we  output  1  RAM write strobe
ram_wdata  output  D_WIDTH  RAM write word
ram_rdata  input  D_WIDTH  RAM read word, valid 1 cycle after ram_addr

Behaviour:
- States: IDLE, LD_RD, LD_DATA, ST_W, RMW_RD, RMW_WR, ERR. All outputs are decoded from registered state and latched request fields.
- Reset (async, rst_n=0): state=IDLE; latched addr/mode/wdata=0. Outputs: req_ready=1, resp_valid=0, resp_err=0, ram_we=0, ram_wdata=0, ram_addr=0, resp_ramout=0, resp_addrmode=0, resp_selectbytes=0.
- Reset mid-operation aborts immediately: ram_we drops asynchronously, no partial write, no resp_valid.
- Accept: in IDLE with req_valid=1 at edge T, latch we/addrmode/addr/wdata. req_ready=0 in every non-IDLE state.
- Misalignment check at accept:
  - half (x01): addr[1:0]==11 is misaligned.
  - word (010): addr[1:0]!=00 is misaligned.
  - byte is never misaligned.
- Transitions from IDLE on accept: misaligned -> ERR. Load -> LD_RD. Store 010 -> ST_W. Store 000/001 -> RMW_RD.
- Store addrmode values other than 000/001 are treated as word stores.
- ERR: resp_valid=1, resp_err=1, no RAM access; -> IDLE.
- LD_RD: ram_addr driven, ram_we=0; -> LD_DATA.
- LD_DATA: resp_valid=1, resp_ramout=ram_rdata; -> IDLE. Load latency: accept at T, response at T+2.
- ST_W: ram_we=1, ram_wdata=wdata, resp_valid=1; -> IDLE. Response at T+1.
- RMW_RD: ram_addr driven, ram_we=0; -> RMW_WR.
- RMW_WR: ram_we=1, resp_valid=1; -> IDLE. Response at T+2; next accept possible at T+3.
- RMW_WR merge into ram_wdata:
  - byte: ram_rdata with lane addr[1:0] (bits 8k+7:8k) replaced by wdata[7:0].
  - half: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], with wdata[15:0].
- resp_addrmode and resp_selectbytes hold the latched values from accept until the next accept.
- req_valid in a non-IDLE state is ignored. The requester must hold req_valid until it sees req_ready high.

Test Plan:
- Reset then load word: RAM[0x10]=0xDEADBEEF; load 010 @0x40 accepted at T -> ram_addr=0x10 at T+1; at T+2 resp_valid=1, resp_ramout=0xDEADBEEF, resp_err=0.
- Byte load: load 100 @0x43 -> resp_selectbytes=11, resp_addrmode=100, resp_ramout = full word, latency 2.
- Store byte RMW: RAM[0]=0x11223344; sb wdata=0xAB @0x01 -> RMW_WR writes 0x1122AB44 at T+2, resp_valid single pulse; subsequent load returns 0x1122AB44.
- Store half upper: RAM[0]=0x11223344; sh wdata=0xCAFE @0x02 -> writes 0xCAFE3344. Store word 0x01020304 @0x04 -> ram_we at T+1 only, no read cycle.
- Misaligned: sw @0x06 and lh @0x03 -> resp_valid=1, resp_err=1 at T+1; ram_we never asserts; RAM unchanged.
- Reset mid-RMW: assert rst_n=0 during RMW_RD -> ram_we stays 0, RAM unchanged, req_ready=1 immediately; a back-to-back req_valid held across busy cycles is accepted only when req_ready=1.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory access controller between the execute stage and a
// single-port, word-wide synchronous RAM without byte enables.
//   - Loads read one word and hand the raw word, the address mode and the
//     byte select to the load-extension stage.
//   - Byte/half stores are read-modify-write; word stores are a single write.
//   - One request in flight at a time, ready/valid handshake upstream.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             upstream handshake (ready only in IDLE)
//   req_we, req_addrmode            store flag, funct3 access mode
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid, resp_err            completion pulse, misaligned flag
//   resp_ramout                     raw RAM word for loads, 0 otherwise
//   resp_addrmode, resp_selectbytes latched mode and addr[1:0]
//   ram_addr, ram_we, ram_wdata     RAM word address, write strobe, write word
//   ram_rdata                       RAM read word, one cycle after ram_addr
module dmem_ctrl #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         req_addrmode,
  input  logic [A_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_wdata,
  output logic               resp_valid,
  output logic               resp_err,
  output logic [D_WIDTH-1:0] resp_ramout,
  output logic [2:0]         resp_addrmode,
  output logic [1:0]         resp_selectbytes,
  output logic [A_WIDTH-3:0] ram_addr,
  output logic               ram_we,
  output logic [D_WIDTH-1:0] ram_wdata,
  input  logic [D_WIDTH-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_RD,
    S_LD_DATA,
    S_ST_W,
    S_RMW_RD,
    S_RMW_WR,
    S_ERR
  } state_e;

  state_e             state_q;
  logic [A_WIDTH-1:0] addr_q;
  logic [2:0]         mode_q;
  logic [D_WIDTH-1:0] wdata_q;

  logic               misaligned_d;
  logic               sub_word_d;
  logic [D_WIDTH-1:0] merge_d;

  // Half accesses may not cross the word; word accesses must be word aligned.
  always_comb begin
    misaligned_d = 1'b0;
    if (req_addrmode[1:0] == 2'b01 && req_addr[1:0] == 2'b11) misaligned_d = 1'b1;
    if (req_addrmode == 3'b010 && req_addr[1:0] != 2'b00)     misaligned_d = 1'b1;
  end

  // Only sb/sh need the read-modify-write path; every other store mode writes
  // the whole word.
  assign sub_word_d = (req_addrmode == 3'b000) || (req_addrmode == 3'b001);

  // NOTE: every variable gets a default before the conditional overrides, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    merge_d = ram_rdata;
    if (mode_q[0]) begin
      if (addr_q[1]) merge_d[31:16] = wdata_q[15:0];
      else           merge_d[15:0]  = wdata_q[15:0];
    end else begin
      merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; the asynchronous reset also returns the state
  // to IDLE at once, which drops ram_we mid-operation without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            mode_q  <= req_addrmode;
            wdata_q <= req_wdata;
            if (misaligned_d)    state_q <= S_ERR;
            else if (!req_we)    state_q <= S_LD_RD;
            else if (sub_word_d) state_q <= S_RMW_RD;
            else                 state_q <= S_ST_W;
          end
        end
        S_LD_RD:  state_q <= S_LD_DATA;
        S_RMW_RD: state_q <= S_RMW_WR;
        S_LD_DATA, S_ST_W, S_RMW_WR, S_ERR: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // All outputs are pure decodes of the registered state and latched fields.
  always_comb begin
    req_ready   = (state_q == S_IDLE);
    resp_valid  = (state_q == S_ERR) || (state_q == S_LD_DATA) ||
                  (state_q == S_ST_W) || (state_q == S_RMW_WR);
    resp_err    = (state_q == S_ERR);
    resp_ramout = (state_q == S_LD_DATA) ? ram_rdata : '0;
    ram_we      = (state_q == S_ST_W) || (state_q == S_RMW_WR);
    ram_wdata   = '0;
    if (state_q == S_ST_W)   ram_wdata = wdata_q;
    if (state_q == S_RMW_WR) ram_wdata = merge_d;
  end

  assign ram_addr         = addr_q[A_WIDTH-1:2];
  assign resp_addrmode    = mode_q;
  assign resp_selectbytes = addr_q[1:0];

endmodule
